// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer. It fetches one
// instruction word, holds it while the instruction executes, then commits
// the next PC chosen by the control unit. It also tracks a sticky interrupt
// request, which is presented only in user mode.
module pc_fetch_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  PCSEL,
    input  logic [31:0] JT,
    input  logic        ADVANCE,
    input  logic        IRQ_IN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    output logic        IRQ,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS4
);

    localparam int unsigned W          = 32;
    localparam int unsigned LW         = W - 1;
    localparam logic [W-1:0] RESET_PC   = 32'h8000_0000;
    localparam logic [W-1:0] ILLOP_PC   = 32'h8000_0004;
    localparam logic [W-1:0] XADR_PC    = 32'h8000_0008;
    localparam logic [W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t          state;
    logic            pending;
    logic            pending_nxt;
    logic            commit;
    logic [LW-1:0]   br_offset;
    logic [LW-1:0]   seq_low;
    logic [LW-1:0]   br_low;
    logic [W-1:0]    next_pc;

    // Next-PC selection; sequential and branch targets keep the supervisor bit
    // and wrap within the low 31 bits.
    always_comb begin
        br_offset = {{13{INSTR[15]}}, INSTR[15:0], 2'b00};
        seq_low   = PC[LW-1:0] + LW'(4);
        br_low    = seq_low + br_offset;
        next_pc   = ILLOP_PC;
        case (PCSEL)
            3'd0:    next_pc = {PC[31], seq_low};
            3'd1:    next_pc = {PC[31], br_low};
            3'd2:    next_pc = {PC[31] & JT[31], JT[30:0]};
            3'd4:    next_pc = XADR_PC;
            default: next_pc = ILLOP_PC;
        endcase
        PC_PLUS4 = {PC[31], seq_low};
    end

    // Sticky interrupt pending: any IRQ_IN sets it, and an XAdr commit clears
    // it unless IRQ_IN is asserted in the same cycle.
    always_comb begin
        commit      = (state == ST_EXEC) && ADVANCE;
        pending_nxt = (commit && (PCSEL == 3'd4)) ? IRQ_IN : (pending | IRQ_IN);
    end

    assign IMEM_ADDR = PC;

    // Fetch/execute sequencer with registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_RST;
            PC          <= RESET_PC;
            INSTR       <= '0;
            INSTR_VALID <= 1'b0;
            IMEM_REQ    <= 1'b0;
            IRQ         <= 1'b0;
            pending     <= 1'b0;
        end else begin
            pending <= pending_nxt;
            case (state)
                ST_RST: begin
                    state    <= ST_FETCH;
                    IMEM_REQ <= 1'b1;
                end
                ST_FETCH: begin
                    if (IMEM_ACK) begin
                        state       <= ST_EXEC;
                        INSTR       <= IMEM_RDATA;
                        INSTR_VALID <= 1'b1;
                        IMEM_REQ    <= 1'b0;
                        IRQ         <= pending_nxt & ~PC[31];
                    end
                end
                ST_EXEC: begin
                    if (ADVANCE) begin
                        state       <= ST_FETCH;
                        PC          <= next_pc & ALIGN_MASK;
                        INSTR_VALID <= 1'b0;
                        IMEM_REQ    <= 1'b1;
                        IRQ         <= 1'b0;
                    end else begin
                        IRQ <= pending_nxt & ~PC[31];
                    end
                end
                default: begin
                    state       <= ST_RST;
                    INSTR_VALID <= 1'b0;
                    IMEM_REQ    <= 1'b0;
                    IRQ         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: a directed vector table, hand-written reset and
// stall sequences, and random stimulus compared against a behavioural model.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  PCSEL;
    logic [31:0] JT;
    logic        ADVANCE;
    logic        IRQ_IN;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_ACK;
    logic [31:0] IMEM_RDATA;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic        IRQ;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;

    always #5 CLK = ~CLK;

    pc_fetch_unit dut (
        .CLK(CLK), .RESET(RESET), .PCSEL(PCSEL), .JT(JT), .ADVANCE(ADVANCE),
        .IRQ_IN(IRQ_IN), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA), .INSTR(INSTR),
        .INSTR_VALID(INSTR_VALID), .IRQ(IRQ), .PC(PC), .PC_PLUS4(PC_PLUS4)
    );

    typedef struct packed {
        logic        rst;
        logic [2:0]  sel;
        logic [31:0] jt;
        logic        adv;
        logic        irqin;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic        e_valid;
        logic        e_irq;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model: phase of the instruction cycle plus architectural state.
    localparam int PH_RST = 0, PH_FETCH = 1, PH_EXEC = 2;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_pend;

    function automatic logic [31:0] f_plus4(input logic [31:0] p);
        return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
    endfunction

    function automatic logic [31:0] f_next(input logic [2:0] sel, input logic [31:0] jt,
                                           input logic [31:0] p, input logic [31:0] ins);
        int          off;
        logic [31:0] t;
        off = int'($signed(ins[15:0]));
        t   = p + 32'd4 + 32'(off * 4);
        case (sel)
            3'd0:    return f_plus4(p);
            3'd1:    return (p & 32'h8000_0000) | (t & 32'h7FFF_FFFF);
            3'd2:    return ((p[31] && jt[31]) ? 32'h8000_0000 : 32'h0) | (jt & 32'h7FFF_FFFC);
            3'd4:    return 32'h8000_0008;
            default: return 32'h8000_0004;
        endcase
    endfunction

    function automatic void addv(input logic rst, input logic [2:0] sel, input logic [31:0] jt,
                                 input logic adv, input logic irqin, input logic ack,
                                 input logic [31:0] rdata, input logic e_req, input logic e_valid,
                                 input logic e_irq, input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rst = rst; v.sel = sel; v.jt = jt; v.adv = adv; v.irqin = irqin; v.ack = ack;
        v.rdata = rdata; v.e_req = e_req; v.e_valid = e_valid; v.e_irq = e_irq;
        v.e_pc = e_pc; v.e_instr = e_instr;
        tbl.push_back(v);
    endfunction

    // Advance the model by one clock using the inputs presented at this edge.
    task automatic model_update();
        if (RESET) begin
            m_phase = PH_RST; m_pc = 32'h8000_0000; m_instr = 32'h0; m_pend = 1'b0;
        end else begin
            if (m_phase == PH_EXEC && ADVANCE && PCSEL == 3'd4) m_pend = IRQ_IN;
            else                                               m_pend = m_pend | IRQ_IN;
            if (m_phase == PH_RST) begin
                m_phase = PH_FETCH;
            end else if (m_phase == PH_FETCH) begin
                if (IMEM_ACK) begin m_instr = IMEM_RDATA; m_phase = PH_EXEC; end
            end else if (ADVANCE) begin
                m_pc = f_next(PCSEL, JT, m_pc, m_instr); m_phase = PH_FETCH;
            end
        end
    endtask

    task automatic drive_step(input logic rst, input logic [2:0] sel, input logic [31:0] jt,
                              input logic adv, input logic irqin, input logic ack,
                              input logic [31:0] rdata);
        RESET = rst; PCSEL = sel; JT = jt; ADVANCE = adv; IRQ_IN = irqin;
        IMEM_ACK = ack; IMEM_RDATA = rdata;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic compare(input string tag, input logic [130:0] got, input logic [130:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {req,valid,irq,addr,pc,instr,pc+4}=%h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [130:0] dut_outs();
        return {IMEM_REQ, INSTR_VALID, IRQ, IMEM_ADDR, PC, INSTR, PC_PLUS4};
    endfunction

    task automatic chk_model(input string tag);
        compare(tag, dut_outs(),
                {m_phase == PH_FETCH, m_phase == PH_EXEC,
                 (m_phase == PH_EXEC) && m_pend && !m_pc[31],
                 m_pc, m_pc, m_instr, f_plus4(m_pc)});
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    logic [31:0] hold_pc, hold_instr;

    initial begin
        RESET = 1'b1; PCSEL = '0; JT = '0; ADVANCE = 1'b0; IRQ_IN = 1'b0;
        IMEM_ACK = 1'b0; IMEM_RDATA = '0;
        m_phase = PH_RST; m_pc = 32'h8000_0000; m_instr = '0; m_pend = 1'b0;

        //   rst sel jt            adv irq ack rdata           req val irq pc             instr
        addv(1, 0, 32'h0,         0, 0, 0, 32'h0,          0, 0, 0, 32'h8000_0000, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0000, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h1234_5678,  0, 1, 0, 32'h8000_0000, 32'h1234_5678);
        addv(0, 2, 32'h0000_0103, 1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_0100, 32'h1234_5678);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0000_FFFE,  0, 1, 0, 32'h0000_0100, 32'h0000_FFFE);
        addv(0, 1, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_00FC, 32'h0000_FFFE);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0000_0003,  0, 1, 0, 32'h0000_00FC, 32'h0000_0003);
        addv(0, 1, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_010C, 32'h0000_0003);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h0000_010C, 32'h0);
        addv(0, 2, 32'h8000_0203, 1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_0200, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h0000_0200, 32'h0);
        addv(0, 4, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0008, 32'h0);
        addv(0, 0, 32'h0,         0, 1, 1, 32'h0,          0, 1, 0, 32'h8000_0008, 32'h0);
        addv(0, 2, 32'h8000_0203, 1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0200, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h8000_0200, 32'h0);
        addv(0, 2, 32'h0000_0020, 1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_0020, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'hAAAA_5555,  0, 1, 1, 32'h0000_0020, 32'hAAAA_5555);
        addv(0, 0, 32'h0,         0, 0, 0, 32'h0,          0, 1, 1, 32'h0000_0020, 32'hAAAA_5555);
        addv(0, 4, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0008, 32'hAAAA_5555);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h8000_0008, 32'h0);
        addv(0, 2, 32'h0000_0040, 1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_0040, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h0000_0040, 32'h0);
        addv(0, 0, 32'h0,         0, 1, 0, 32'h0,          0, 1, 1, 32'h0000_0040, 32'h0);
        addv(0, 4, 32'h0,         1, 1, 0, 32'h0,          1, 0, 0, 32'h8000_0008, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h8000_0008, 32'h0);
        addv(0, 2, 32'h0000_0044, 1, 0, 0, 32'h0,          1, 0, 0, 32'h0000_0044, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 1, 32'h0000_0044, 32'h0);
        addv(0, 7, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0004, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0000_0011,  0, 1, 0, 32'h8000_0004, 32'h0000_0011);
        addv(0, 1, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_004C, 32'h0000_0011);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'h8000_004C, 32'h0);
        addv(0, 2, 32'hFFFF_FFFC, 1, 0, 0, 32'h0,          1, 0, 0, 32'hFFFF_FFFC, 32'h0);
        addv(0, 0, 32'h0,         0, 0, 1, 32'h0,          0, 1, 0, 32'hFFFF_FFFC, 32'h0);
        addv(0, 0, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0000, 32'h0);
        addv(0, 4, 32'h0,         1, 0, 0, 32'h0,          1, 0, 0, 32'h8000_0000, 32'h0);

        @(negedge CLK);

        // Directed table.
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive_step(v.rst, v.sel, v.jt, v.adv, v.irqin, v.ack, v.rdata);
            compare($sformatf("table[%0d]", i), dut_outs(),
                    {v.e_req, v.e_valid, v.e_irq, v.e_pc, v.e_pc, v.e_instr, f_plus4(v.e_pc)});
        end

        // Reset asserted mid-fetch with the acknowledge held high.
        drive_step(1, 0, 0, 0, 0, 0, 0);
        drive_step(0, 0, 0, 0, 0, 0, 0);
        drive_step(0, 0, 0, 0, 0, 0, 0);
        chk_model("rst_mid_fetch_pre");
        drive_step(1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk_model("rst_mid_fetch");
        chk32("rst_mid_fetch_req", {31'h0, IMEM_REQ}, 32'h0);
        chk32("rst_mid_fetch_pc", PC, 32'h8000_0000);
        chk32("rst_mid_fetch_instr", INSTR, 32'h0);
        drive_step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk_model("rst_release_rst_state");

        // Slow memory: five cycles without ACK, then three EXEC cycles without ADVANCE.
        drive_step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_step(0, 3'($urandom_range(0, 7)), $urandom, 1'b1, 1'b0, 1'b0, $urandom);
            chk32($sformatf("stall_fetch_addr[%0d]", i), IMEM_ADDR, 32'h8000_0000);
        end
        drive_step(0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);
        hold_pc = PC; hold_instr = INSTR;
        chk32("stall_fetch_instr", INSTR, 32'h0BAD_F00D);
        for (int i = 0; i < 3; i++) begin
            drive_step(0, 3'($urandom_range(0, 7)), $urandom, 1'b0, 1'b0, 1'($urandom), $urandom);
            chk32($sformatf("stall_exec_instr[%0d]", i), INSTR, hold_instr);
            chk32($sformatf("stall_exec_pc[%0d]", i), PC, hold_pc);
        end
        drive_step(0, 0, 0, 1, 0, 0, 0);
        chk32("stall_advance_pc", PC, 32'h8000_0004);
        chk_model("stall_advance");

        // Random stimulus against the model.
        drive_step(1, 0, 0, 0, 0, 0, 0);
        chk_model("rand_reset");
        for (int i = 0; i < 600; i++) begin
            drive_step($urandom_range(0, 63) == 0, 3'($urandom_range(0, 7)), $urandom,
                       1'($urandom), $urandom_range(0, 7) == 0, 1'($urandom), $urandom);
            chk_model($sformatf("rand[%0d]", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge clock, sole clock.
REQ-002 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port PCSEL  input  3  next-PC select from control unit: 0 PC+4, 1 branch, 2 JT, 3 ILLOP, 4 XAdr.
REQ-004 SHALL have port JT  input  32  jump target (Ra register value).
REQ-005 SHALL have port ADVANCE  input  1  current instruction's execute cycle completes; commit next PC.
REQ-006 SHALL have port IRQ_IN  input  1  external interrupt request, level.
REQ-007 SHALL have port IMEM_REQ  output  1  instruction-memory read request.
REQ-008 SHALL have port IMEM_ADDR  output  32  instruction-memory word address.
REQ-009 SHALL have port IMEM_ACK  input  1  read data valid this cycle.
REQ-010 SHALL have port IMEM_RDATA  input  32  instruction word.
REQ-011 SHALL have port INSTR  output  32  latched instruction to control unit and datapath.
REQ-012 SHALL have port INSTR_VALID  output  1  INSTR is stable and executing.
REQ-013 SHALL have port IRQ  output  1  interrupt request to control unit.
REQ-014 SHALL have port PC  output  32  address of the executing instruction.
REQ-015 SHALL have port PC_PLUS4  output  32  PC+4, for register write-back of return address.

Function
REQ-016 SHALL implement states RST, FETCH, EXEC; RST lasts exactly one cycle after RESET deasserts, then FETCH.
REQ-017 FETCH: IMEM_REQ=1, IMEM_ADDR=PC; on IMEM_ACK latch IMEM_RDATA into INSTR and go to EXEC next cycle; without ACK stay in FETCH indefinitely.
REQ-018 EXEC: INSTR_VALID=1, IMEM_REQ=0; on ADVANCE load the next PC and go to FETCH; otherwise hold PC and INSTR.
REQ-019 IMEM_ACK outside FETCH SHALL be ignored; ADVANCE outside EXEC SHALL be ignored.
REQ-020 Next PC by PCSEL: 0 PC+4; 1 PC+4+4*sign-extend(INSTR[15:0]); 2 {PC[31] & JT[31], JT[30:2], 2'b00}; 3 0x80000004; 4 0x80000008; 5-7 SHALL be treated as 3.
REQ-021 For PCSEL 0 and 1, bit 31 (supervisor) SHALL be preserved from the current PC; only bits 30:0 take the 32-bit sum; wrap-around within bits 30:0 is modulo 2^31.
REQ-022 PC[1:0] SHALL always read 0.
REQ-023 PC_PLUS4 SHALL equal {PC[31], PC[30:0]+4} combinationally.
REQ-024 A sticky pending flag SHALL set on any cycle with IRQ_IN=1.
REQ-025 IRQ SHALL be 1 only in EXEC with pending=1 and PC[31]=0; never in supervisor mode.
REQ-026 Pending SHALL clear on an ADVANCE with PCSEL=4; if IRQ_IN=1 in that same cycle, set wins and pending stays 1.
REQ-027 INSTR SHALL change only on an accepted IMEM_ACK in FETCH.
REQ-028 Branch and ADVANCE in the same cycle as a pending IRQ: PCSEL as presented governs; no internal override.

Reset
REQ-029 RESET SHALL win over all other inputs in any state, including mid-FETCH; the request is abandoned and IMEM_REQ=0 in the following cycle.
REQ-030 After reset: state RST, PC=0x80000000, INSTR=0, INSTR_VALID=0, IMEM_REQ=0, IRQ=0, pending=0.
REQ-031 First fetch after reset SHALL be at IMEM_ADDR=0x80000000, the second cycle after RESET deasserts.

Verification
REQ-032 Reset then ACK of 0x12345678 on first FETCH cycle -> INSTR=0x12345678, INSTR_VALID=1 next cycle, PC=0x80000000.
REQ-033 PC=0x00000100, INSTR[15:0]=0xFFFE, ADVANCE with PCSEL=1 -> next IMEM_ADDR=0x000000FC; with INSTR[15:0]=0x0003 -> 0x00000110.
REQ-034 PC=0x00000040, JT=0x80000203, PCSEL=2 -> next PC=0x00000200 (user cannot enter supervisor); from PC=0x80000040 -> 0x80000200.
REQ-035 IRQ_IN pulse one cycle while PC=0x80000010 -> IRQ=0; after JMP to 0x00000020 and fetch -> IRQ=1 in EXEC; ADVANCE with PCSEL=4 -> PC=0x80000008, IRQ=0.
REQ-036 RESET asserted mid-FETCH with ACK held high -> INSTR not updated, PC=0x80000000, IMEM_REQ=0 next cycle.
REQ-037 ACK delayed 5 cycles, ADVANCE held 0 for 3 EXEC cycles -> IMEM_ADDR stable in FETCH, INSTR and PC stable in EXEC throughout.
